fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage and producer side of the IF/ID pipeline register.
- Owns the PC and issues single-outstanding Wishbone-classic reads on the instruction bus.
- Presents pc, pc+4, instruction, misaligned-address flag and a valid strobe to IF/ID.
- Honours stall (hold) and flush/redirect (from branch/trap logic), including dropping in-flight responses.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0033, instruction presented when no valid fetch (add x0,x0,x0)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  downstream stall; IF/ID holds, fetch must not advance
flush  in  1  redirect request; discards current/pending fetch
flush_target  in  32  new PC when flush=1
imem_addr  out  32  bus address
imem_cyc  out  1  bus cycle active
imem_stb  out  1  strobe (equal to imem_cyc)
imem_ack  in  1  response valid; may assert in the same cycle as stb
imem_rdata  in  32  instruction data, valid with ack
if_pc  out  32  PC of presented instruction
if_pc_add4  out  32  if_pc+4, modulo 2^32
if_exc_addr  out  1  presented PC misaligned (pc[1:0]!=0)
if_inst  out  32  presented instruction
if_ready  out  1  if_* valid this cycle

Behaviour:
- Reset (clk edge with rst=1):
  - pc<=RESET_ADDR, state<=FETCH.
  - Outputs during and after the reset cycle: cyc=stb=0 while rst; if_ready=0, if_inst=NOP_INST, if_exc_addr=0, if_pc=pc, if_pc_add4=pc+4.
  - Reset mid-transaction abandons the bus cycle; the late ack is ignored.
- Registers: pc, addr_q (address of the outstanding request), hold_q (captured instruction), state.
- Outputs are combinational from these registers plus imem_ack/imem_rdata.
- States:
  - FETCH:
    - cyc=stb=1, imem_addr=pc.
    - if_ready=imem_ack, if_inst=imem_rdata when ack, else NOP_INST.
  - HOLD:
    - Instruction is captured and a stall is pending. No bus activity.
    - if_ready=1, if_inst=hold_q.
  - KILL:
    - A flush arrived while a request was outstanding. cyc=stb=1, imem_addr=addr_q.
    - if_ready=0. Wait for the ack, then discard rdata.
  - EXC:
    - pc misaligned. No bus access.
    - if_ready=1, if_exc_addr=1, if_inst=NOP_INST.
  - PARK:
    - Exception handed off. No bus activity, if_ready=0.
    - Wait for flush (trap redirect).
- Transitions (flush has priority over stall in every state):
  - flush in FETCH without ack: pc<=flush_target, addr_q<=old pc, go KILL.
  - flush in FETCH with ack, or in HOLD/EXC/PARK: pc<=flush_target. Response/held data is dropped. Go FETCH, or EXC if flush_target[1:0]!=0.
  - flush in KILL: pc<=flush_target (newest target wins). Stay KILL until ack.
  - KILL with ack: go FETCH, or EXC if pc misaligned.
  - FETCH with ack and !stall: pc<=pc+4, stay FETCH. This gives 1 instr/cycle with zero-wait memory.
  - FETCH with ack and stall: hold_q<=imem_rdata, go HOLD.
  - HOLD with !stall: pc<=pc+4, go FETCH.
  - EXC with !stall: go PARK.
  - FETCH without ack: remain. Stall has no effect; the request stays on the bus.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Misalignment is checked whenever pc is loaded. RESET_ADDR must be word aligned.
- Exactly one if_ready=1 && !stall cycle per fetched instruction. No instruction is duplicated or lost across stalls.

Decomposition:
- Shared package `titan_pkg`: NOP_INST constant, state enum encoding (FETCH, HOLD, KILL, EXC, PARK), XLEN=32.
- Single module. No sub-module is needed; the hold register is inline.

Test Plan:
- Reset, zero-wait memory returning rdata=addr ^ 32'hA5A5_0000 → if_pc sequence 0,4,8,C on consecutive cycles, each with if_ready=1 and matching if_inst.
- Ack at pc=8 with stall held 3 cycles → HOLD; if_ready=1 with if_inst held constant for 3 cycles; bus idle; pc=C is fetched the cycle after stall drops.
- 2-wait-state memory, flush_target=0x100 one cycle after stb at 0x10 → stb stays at 0x10 until ack, that data is never presented (if_ready=0), next request at 0x100.
- flush_target=0x102 → no bus request, if_ready=1, if_exc_addr=1, if_inst=0x33; next cycle if_ready=0 (PARK); flush to 0x200 resumes fetching at 0x200.
- Flush and ack in the same FETCH cycle → rdata dropped, next imem_addr=flush_target; flush+stall together → flush wins.
- rst asserted while KILL pending → cyc=0 next cycle, pc=RESET_ADDR; a stale ack arriving afterwards is not presented.

Source files
------------

// File: rtl/titan_pkg.sv
// Shared pipeline types and constants.
// Used by the fetch stage and its IF/ID bundle.
package titan_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0033;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    HOLD  = 3'd1,
    KILL  = 3'd2,
    EXC   = 3'd3,
    PARK  = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_add4;
    logic            exc_addr;
    logic [XLEN-1:0] inst;
    logic            ready;
  } if_id_t;

  function automatic logic misaligned(input logic [XLEN-1:0] a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Wishbone-classic instruction bus, single outstanding read.
// The fetch stage is master, instruction memory is slave.
interface fetch_unit_if;
  import titan_pkg::*;

  logic [XLEN-1:0] addr;
  logic            cyc;
  logic            stb;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (
    output addr, cyc, stb,
    input  ack, rdata
  );

  modport slave (
    input  addr, cyc, stb,
    output ack, rdata
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the imem bus,
// and produces the IF/ID bundle with stall/flush handling.
module fetch_unit
  import titan_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = titan_pkg::NOP_INST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic [31:0]         flush_target,
  fetch_unit_if.master        imem,
  output logic [31:0]         if_pc,
  output logic [31:0]         if_pc_add4,
  output logic                if_exc_addr,
  output logic [31:0]         if_inst,
  output logic                if_ready
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  pc_add4;
  if_id_t       ifid;

  assign pc_add4 = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_ADDR;
      addr_q  <= RESET_ADDR;
      hold_q  <= NOP_INST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    unique case (state_q)
      FETCH: begin
        if (flush) begin
          pc_d = flush_target;
          if (imem.ack) begin
            state_d = misaligned(flush_target) ? EXC : FETCH;
          end else begin
            addr_d  = pc_q;
            state_d = KILL;
          end
        end else if (imem.ack) begin
          if (stall) begin
            hold_d  = imem.rdata;
            state_d = HOLD;
          end else begin
            pc_d = pc_add4;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          pc_d    = flush_target;
          state_d = misaligned(flush_target) ? EXC : FETCH;
        end else if (!stall) begin
          pc_d    = pc_add4;
          state_d = FETCH;
        end
      end
      KILL: begin
        // newest redirect wins; the stale response is just drained
        if (flush) pc_d = flush_target;
        if (imem.ack) begin
          state_d = misaligned(pc_d) ? EXC : FETCH;
        end
      end
      EXC: begin
        if (flush) begin
          pc_d    = flush_target;
          state_d = misaligned(flush_target) ? EXC : FETCH;
        end else if (!stall) begin
          state_d = PARK;
        end
      end
      PARK: begin
        if (flush) begin
          pc_d    = flush_target;
          state_d = misaligned(flush_target) ? EXC : FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_comb begin
    imem.cyc      = 1'b0;
    imem.addr     = pc_q;
    ifid.pc       = pc_q;
    ifid.pc_add4  = pc_add4;
    ifid.exc_addr = 1'b0;
    ifid.inst     = NOP_INST;
    ifid.ready    = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem.cyc   = 1'b1;
        ifid.ready = imem.ack;
        if (imem.ack) ifid.inst = imem.rdata;
      end
      HOLD: begin
        ifid.ready = 1'b1;
        ifid.inst  = hold_q;
      end
      KILL: begin
        imem.cyc  = 1'b1;
        imem.addr = addr_q;
      end
      EXC: begin
        ifid.ready    = 1'b1;
        ifid.exc_addr = 1'b1;
      end
      PARK: begin
        ifid.ready = 1'b0;
      end
      default: begin
        ifid.ready = 1'b0;
      end
    endcase
    // reset abandons any bus cycle and masks late responses
    if (rst) begin
      imem.cyc      = 1'b0;
      ifid.ready    = 1'b0;
      ifid.exc_addr = 1'b0;
      ifid.inst     = NOP_INST;
    end
  end

  assign imem.stb    = imem.cyc;
  assign if_pc       = ifid.pc;
  assign if_pc_add4  = ifid.pc_add4;
  assign if_exc_addr = ifid.exc_addr;
  assign if_inst     = ifid.inst;
  assign if_ready    = ifid.ready;

endmodule
